// File: rtl/stroke_painter.sv
// Paints a (w+1)x(w+1) brush stroke into a linear frame buffer, one pixel per accepted write.
// Optional build macro STROKE_ROUND_EN drops the four corner pixels for strokes with w >= 2.
module stroke_painter #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        nf_in,
    input  logic        draw_in,
    input  logic [9:0]  cursor_loc_x,
    input  logic [8:0]  cursor_loc_y,
    input  logic [3:0]  cursor_color,
    input  logic [2:0]  stroke_width,
    output logic        wr_valid_out,
    input  logic        wr_ready_in,
    output logic [18:0] wr_addr_out,
    output logic [3:0]  wr_data_out,
    output logic        busy_out,
    output logic        done_out
);
    typedef enum logic [1:0] {IDLE, PAINT, DONE} state_t;

    localparam logic [10:0] H_LIM = 11'(H_ACTIVE);
    localparam logic [9:0]  V_LIM = 10'(V_ACTIVE);
    localparam logic [18:0] H_MUL = 19'(H_ACTIVE);

    state_t      state;
    logic [9:0]  pos_x;
    logic [8:0]  pos_y;
    logic [2:0]  width;
    logic [2:0]  dx;
    logic [2:0]  dy;

    // Evaluated pixel: the origin of a new stroke in IDLE, otherwise the next offset in raster order.
    logic [9:0]  ev_x;
    logic [8:0]  ev_y;
    logic [2:0]  ev_dx;
    logic [2:0]  ev_dy;
    logic [10:0] px;
    logic [9:0]  py;
    logic [18:0] ev_addr;
    logic        ev_skip;
    logic        last;
    logic        advance;

`ifdef STROKE_ROUND_EN
    logic [2:0]  ev_w;
    assign ev_w = (state == IDLE) ? stroke_width : width;
`endif

    always_comb begin
        ev_x  = pos_x;
        ev_y  = pos_y;
        ev_dx = 3'd0;
        ev_dy = 3'd0;
        if (state == IDLE) begin
            ev_x = cursor_loc_x;
            ev_y = cursor_loc_y;
        end else if (dx == width) begin
            ev_dy = dy + 3'd1;
        end else begin
            ev_dx = dx + 3'd1;
            ev_dy = dy;
        end
        px      = {1'b0, ev_x} + {8'd0, ev_dx};
        py      = {1'b0, ev_y} + {7'd0, ev_dy};
        ev_skip = (px >= H_LIM) || (py >= V_LIM);
`ifdef STROKE_ROUND_EN
        if (ev_w >= 3'd2 && (ev_dx == 3'd0 || ev_dx == ev_w) &&
            (ev_dy == 3'd0 || ev_dy == ev_w))
            ev_skip = 1'b1;
`endif
        // 19 bits hold every in-range address; clipped pixels never reach the bus.
        ev_addr = {9'd0, py} * H_MUL + {8'd0, px};
    end

    assign last    = (dx == width) && (dy == width);
    assign advance = !wr_valid_out || wr_ready_in;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state        <= IDLE;
            pos_x        <= '0;
            pos_y        <= '0;
            width        <= '0;
            dx           <= '0;
            dy           <= '0;
            wr_valid_out <= 1'b0;
            wr_addr_out  <= '0;
            wr_data_out  <= '0;
            busy_out     <= 1'b0;
            done_out     <= 1'b0;
        end else begin
            done_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (nf_in && draw_in) begin
                        pos_x        <= cursor_loc_x;
                        pos_y        <= cursor_loc_y;
                        width        <= stroke_width;
                        dx           <= '0;
                        dy           <= '0;
                        wr_valid_out <= !ev_skip;
                        wr_addr_out  <= ev_addr;
                        wr_data_out  <= cursor_color;
                        busy_out     <= 1'b1;
                        state        <= PAINT;
                    end
                end
                PAINT: begin
                    if (advance) begin
                        if (last) begin
                            wr_valid_out <= 1'b0;
                            done_out     <= 1'b1;
                            state        <= DONE;
                        end else begin
                            dx           <= ev_dx;
                            dy           <= ev_dy;
                            wr_valid_out <= !ev_skip;
                            wr_addr_out  <= ev_addr;
                        end
                    end
                end
                DONE: begin
                    busy_out <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stroke_painter.sv
// Self-checking bench for stroke_painter: directed strokes plus random strokes against a raster-list model.
module tb_stroke_painter;
    localparam int H = 640;
    localparam int V = 480;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        nf = 1'b0;
    logic        draw = 1'b0;
    logic [9:0]  cx = '0;
    logic [8:0]  cy = '0;
    logic [3:0]  ccol = '0;
    logic [2:0]  cw = '0;
    logic        ready = 1'b1;
    logic        valid;
    logic [18:0] addr;
    logic [3:0]  data;
    logic        busy;
    logic        done;

    int n_assert = 0;
    int n_fail = 0;

    stroke_painter #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .clk_in(clk), .rst_in(rst), .nf_in(nf), .draw_in(draw),
        .cursor_loc_x(cx), .cursor_loc_y(cy), .cursor_color(ccol), .stroke_width(cw),
        .wr_valid_out(valid), .wr_ready_in(ready), .wr_addr_out(addr), .wr_data_out(data),
        .busy_out(busy), .done_out(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // mode 0: ready always high, 1: ready toggles, 2: ready random
    task automatic stroke(input int x, input int y, input int c, input int w, input int mode);
        int  exp_q[$];
        int  n_exp, stalls, busy_cnt, done_cnt, done_at, writes;
        bit  ended, stalled, corner;
        logic [18:0] pa;
        logic [3:0]  pd;
        for (int j = 0; j <= w; j++)
            for (int i = 0; i <= w; i++) begin
                corner = 1'b0;
`ifdef STROKE_ROUND_EN
                corner = (w >= 2) && (i == 0 || i == w) && (j == 0 || j == w);
`endif
                if (x + i < H && y + j < V && !corner) exp_q.push_back((y + j) * H + x + i);
            end
        n_exp = exp_q.size();
        stalls = 0; busy_cnt = 0; done_cnt = 0; done_at = -1; writes = 0;
        ended = 1'b0; stalled = 1'b0; pa = '0; pd = '0;

        @(negedge clk);
        nf = 1'b1; draw = 1'b1;
        cx = 10'(x); cy = 9'(y); ccol = 4'(c); cw = 3'(w);
        @(negedge clk);
        nf = 1'b0;
        cx = 10'($urandom); cy = 9'($urandom); ccol = 4'($urandom); cw = 3'($urandom);
        for (int cyc = 0; cyc < 1000; cyc++) begin
            if (!busy) begin
                ended = 1'b1;
                break;
            end
            busy_cnt++;
            if (done) begin
                done_cnt++;
                done_at = busy_cnt;
            end
            if (stalled) begin
                check("stall_valid", valid, 1);
                check("stall_addr", addr, pa);
                check("stall_data", data, pd);
            end
            stalled = 1'b0;
            case (mode)
                0:       ready = 1'b1;
                1:       ready = (cyc % 2 == 0);
                default: ready = 1'($urandom_range(0, 1));
            endcase
            if (valid) begin
                if (ready) begin
                    writes++;
                    if (exp_q.size() > 0) begin
                        check("wr_addr", addr, exp_q.pop_front());
                        check("wr_data", data, c);
                    end
                end else begin
                    stalls++;
                    stalled = 1'b1;
                    pa = addr;
                    pd = data;
                end
            end
            nf = ($urandom_range(0, 3) == 0);
            @(negedge clk);
        end
        nf = 1'b0;
        ready = 1'b1;
        check("stroke_ended", ended, 1);
        check("write_count", writes, n_exp);
        check("done_count", done_cnt, 1);
        check("done_last_busy", done_at, busy_cnt);
        check("busy_cycles", busy_cnt, (w + 1) * (w + 1) + stalls + 1);
    endtask

    initial begin
        #1;
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_addr", addr, 0);
        check("rst_data", data, 0);
        @(negedge clk);
        rst = 1'b0;

        // pen up: frame strobe alone does nothing
        @(negedge clk);
        nf = 1'b1; draw = 1'b0; cx = 10'd5; cy = 9'd5; cw = 3'd2;
        @(negedge clk);
        nf = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("penup_busy", busy, 0);
            check("penup_valid", valid, 0);
            @(negedge clk);
        end

        stroke(100, 50, 5, 0, 0);
        stroke(10, 20, 3, 2, 0);
        stroke(10, 20, 7, 2, 1);
        stroke(639, 479, 12, 3, 0);
        stroke(630, 475, 1, 7, 2);
        stroke(1000, 10, 4, 1, 0);

        // reset while the 4th pixel of a w=3 stroke is on the bus
        @(negedge clk);
        nf = 1'b1; draw = 1'b1; cx = 10'd200; cy = 9'd100; cw = 3'd3; ccol = 4'd9; ready = 1'b1;
        @(negedge clk);
        nf = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_valid", valid, 1);
        check("pre_rst_addr", addr, 100 * H + 203);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_addr", addr, 0);
        check("mid_rst_data", data, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("post_rst_done", done, 0);
            check("post_rst_busy", busy, 0);
            @(negedge clk);
        end
        stroke(200, 100, 9, 3, 0);

        for (int n = 0; n < 20; n++) begin
            int rx, ry;
            rx = ($urandom_range(0, 1) == 1) ? $urandom_range(630, 639) : $urandom_range(0, 639);
            ry = ($urandom_range(0, 1) == 1) ? $urandom_range(470, 479) : $urandom_range(0, 479);
            stroke(rx, ry, $urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/stroke_painter.md
STROKE_PAINTER -- requirements
Module: stroke_painter

Interface
REQ-001: Parameter H_ACTIVE, default 640, canvas width in pixels.
REQ-002: Parameter V_ACTIVE, default 480, canvas height in pixels.
REQ-003: clk_in  input  1  system clock; all state advances on its rising edge.
REQ-004: rst_in  input  1  reset, asynchronous and active-high.
REQ-005: nf_in  input  1  new-frame strobe, one cycle high per frame.
REQ-006: draw_in  input  1  pen-down; high means paint at this frame.
REQ-007: cursor_loc_x  input  10  cursor column, 0..H_ACTIVE-1.
REQ-008: cursor_loc_y  input  9  cursor row, 0..V_ACTIVE-1.
REQ-009: cursor_color  input  4  palette index to paint.
REQ-010: stroke_width  input  3  stroke size w, 0..7.
REQ-011: wr_valid_out  output  1  pixel write request valid.
REQ-012: wr_ready_in  input  1  frame-buffer write port ready.
REQ-013: wr_addr_out  output  19  linear pixel address, py*H_ACTIVE+px.
REQ-014: wr_data_out  output  4  pixel colour.
REQ-015: busy_out  output  1  high while a stroke is being painted.
REQ-016: done_out  output  1  one-cycle pulse when a stroke completes.

Function
REQ-017: The FSM SHALL have states IDLE, PAINT and DONE.
REQ-018: In IDLE, nf_in=1 with draw_in=1 SHALL latch x, y, color and w, clear dx and dy, and enter PAINT on the next edge.
REQ-019: In IDLE, nf_in=1 with draw_in=0 SHALL leave the FSM in IDLE with no writes issued.
REQ-020: nf_in in PAINT or DONE SHALL be ignored, and the frame is dropped.
REQ-021: In PAINT the block SHALL visit offsets dx,dy in 0..w, dx innermost, targeting pixel (x+dx, y+dy).
REQ-022: A pixel with x+dx >= H_ACTIVE or y+dy >= V_ACTIVE SHALL be skipped, taking one cycle with wr_valid_out=0.
REQ-023: For a non-skipped pixel, wr_valid_out SHALL be 1, with wr_addr_out and wr_data_out held stable until the cycle where wr_ready_in=1.
REQ-024: The pixel SHALL advance only on wr_valid_out & wr_ready_in, or on a skip.
REQ-025: Zero-wait throughput SHALL be one pixel per cycle; a stroke of width w takes (w+1)^2 PAINT cycles plus stalls.
REQ-026: The address SHALL be computed at full width, with no truncation for in-range pixels.
REQ-027: Changes on the cursor_* and stroke_width inputs during PAINT SHALL have no effect on the stroke in progress.
REQ-028: After the last offset (dx=w, dy=w) is accepted or skipped, the FSM SHALL enter DONE.
REQ-029: DONE SHALL assert done_out for exactly one cycle, then return to IDLE.
REQ-030: busy_out SHALL be 1 in PAINT and DONE, and 0 in IDLE.
REQ-031: When every pixel is clipped, the block SHALL still pass through DONE and pulse done_out, with zero writes.

Reset
REQ-032: While rst_in=1, the FSM SHALL be in IDLE, and wr_valid_out, busy_out and done_out SHALL be 0.
REQ-033: While rst_in=1, wr_addr_out, wr_data_out, dx and dy SHALL be 0.
REQ-034: Reset mid-PAINT SHALL abort the stroke immediately, drop any pending write, and issue no done_out.
REQ-035: After reset release, the next qualifying nf_in SHALL start a fresh stroke.

Configuration
REQ-036: Macro STROKE_ROUND_EN defined: for w>=2, the four corner offsets (dx in {0,w} and dy in {0,w}) SHALL be treated as skipped pixels, each taking one cycle with no write.
REQ-037: Macro STROKE_ROUND_EN undefined: every offset SHALL be painted, forming a full square; for w<2 the output is identical either way.

Verification
REQ-038: Pen-down at x=100, y=50, w=0, color=5, ready=1 -> exactly one write, addr 32100, data 5, then done_out one cycle later.
REQ-039: x=10, y=20, w=2, ready=1, macro undefined -> 9 writes in raster order from addr 12810, ending at 14092; busy_out high for 10 cycles.
REQ-040: Same stroke with ready toggling 1/0 -> addr and data stable while stalled, 9 accepted writes, no duplicates or skips.
REQ-041: x=639, y=479, w=3 -> 1 write, addr 307199, then done_out; x=639, y=479 with all offsets out of range beyond the origin -> only the origin is written.
REQ-042: rst_in pulsed during the 4th pixel of a w=3 stroke -> wr_valid_out drops asynchronously, no done_out, and the next nf_in restarts from dx=dy=0.
REQ-043: STROKE_ROUND_EN defined, w=2 -> 5 writes (corners absent), with done_out after 9 PAINT cycles.
